// File: rtl/vector_sum.sv
// Pipelined unsigned reduction: registers DIM elements, then sums them through a
// registered binary adder tree with one result per clock.
module vector_sum #(
  parameter int DIM = 1,
  parameter int W_u = 8
) (
  input  logic                             Clock,
  input  logic                             Reset_n,
  input  logic [DIM*W_u-1:0]               u,
  output logic [W_u+$clog2(DIM+1)-1:0]     sum,
  output logic                             readEn
);

  localparam int SUM_W  = W_u + $clog2(DIM + 1);
  localparam int LEVELS = $clog2(DIM);
  localparam int LAT    = 1 + LEVELS;

  function automatic int node_cnt(input int level);
    int n;
    n = DIM;
    for (int i = 0; i < level; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // Level 0 holds the zero-extended inputs; each later level halves the node count,
  // an odd trailing node is carried forward unchanged.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = node_cnt(l);
    for (genvar j = 0; j < N; j++) begin : g_node
      logic [SUM_W-1:0] r;
      if (l == 0) begin : g_in
        always_ff @(posedge Clock or negedge Reset_n) begin
          if (!Reset_n) r <= '0;
          else          r <= SUM_W'(u[j*W_u +: W_u]);
        end
      end else if (2*j + 1 < node_cnt(l - 1)) begin : g_add
        always_ff @(posedge Clock or negedge Reset_n) begin
          if (!Reset_n) r <= '0;
          else          r <= g_lvl[l-1].g_node[2*j].r + g_lvl[l-1].g_node[2*j+1].r;
        end
      end else begin : g_pass
        always_ff @(posedge Clock or negedge Reset_n) begin
          if (!Reset_n) r <= '0;
          else          r <= g_lvl[l-1].g_node[2*j].r;
        end
      end
    end
  end

  assign sum = g_lvl[LEVELS].g_node[0].r;

  logic [LAT-1:0] vld;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) vld <= '0;
    else          vld <= (vld << 1) | LAT'(1);
  end

  assign readEn = vld[LAT-1];

endmodule

// File: tb/tb_vector_sum.sv
// Randomized bench for vector_sum across DIM = 1, 3, 4, 5 against a latency-queue
// model of the element sums.
module tb_vector_sum;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clock = ~Clock;

  logic [7:0]  u1;
  logic [23:0] u3;
  logic [15:0] u4;
  logic [39:0] u5;
  logic [8:0]  s1;
  logic [9:0]  s3;
  logic [6:0]  s4;
  logic [10:0] s5;
  logic        e1, e3, e4, e5;

  vector_sum #(.DIM(1), .W_u(8)) u_d1 (.Clock(Clock), .Reset_n(Reset_n), .u(u1), .sum(s1), .readEn(e1));
  vector_sum #(.DIM(3), .W_u(8)) u_d3 (.Clock(Clock), .Reset_n(Reset_n), .u(u3), .sum(s3), .readEn(e3));
  vector_sum #(.DIM(4), .W_u(4)) u_d4 (.Clock(Clock), .Reset_n(Reset_n), .u(u4), .sum(s4), .readEn(e4));
  vector_sum #(.DIM(5), .W_u(8)) u_d5 (.Clock(Clock), .Reset_n(Reset_n), .u(u5), .sum(s5), .readEn(e5));

  int          dims [4] = '{1, 3, 4, 5};
  int          ws   [4] = '{8, 8, 4, 8};
  string       names[4] = '{"d1", "d3", "d4", "d5"};
  logic [63:0] cur  [4];
  int          hist [4][$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int vsum(input logic [63:0] v, input int d, input int w);
    int s;
    s = 0;
    for (int i = 0; i < d; i++) s += int'((v >> (i * w)) & ((64'd1 << w) - 64'd1));
    return s;
  endfunction

  function automatic int got_sum(input int k);
    case (k)
      0: return int'(s1);
      1: return int'(s3);
      2: return int'(s4);
      default: return int'(s5);
    endcase
  endfunction

  function automatic int got_en(input int k);
    case (k)
      0: return int'(e1);
      1: return int'(e3);
      2: return int'(e4);
      default: return int'(e5);
    endcase
  endfunction

  task automatic apply();
    u1 = cur[0][7:0];
    u3 = cur[1][23:0];
    u4 = cur[2][15:0];
    u5 = cur[3][39:0];
  endtask

  task automatic randomize_cur();
    for (int k = 0; k < 4; k++) begin
      logic [63:0] m;
      m = (64'd1 << (dims[k] * ws[k])) - 64'd1;
      cur[k] = {$urandom, $urandom} & m;
    end
  endtask

  // Entered at a falling edge; drives cur, takes one rising edge, checks, returns at the next falling edge.
  task automatic cycle();
    apply();
    @(posedge Clock);
    #1;
    for (int k = 0; k < 4; k++) begin
      int lat;
      int n;
      lat = 1 + $clog2(dims[k]);
      hist[k].push_back(vsum(cur[k], dims[k], ws[k]));
      n = hist[k].size();
      check({names[k], "_en"}, got_en(k), (n >= lat) ? 1 : 0);
      if (n >= lat) check({names[k], "_sum"}, got_sum(k), hist[k][n - lat]);
    end
    @(negedge Clock);
  endtask

  task automatic check_reset_state();
    for (int k = 0; k < 4; k++) begin
      check({names[k], "_rst_sum"}, got_sum(k), 0);
      check({names[k], "_rst_en"}, got_en(k), 0);
      hist[k].delete();
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) cur[k] = '0;
    apply();
    repeat (10) @(negedge Clock);
    check_reset_state();
    Reset_n = 1'b1;

    cur[0] = 64'h08;
    cur[1] = 64'hC8_00_07;
    cur[2] = 64'h1111;
    cur[3] = 64'h05_04_03_02_01;
    repeat (5) cycle();

    cur[2] = 64'h2222;
    cur[3] = 64'hFF_FF_FF_FF_FF;
    cycle();
    cur[2] = 64'hFFFF;
    repeat (5) cycle();

    for (int i = 0; i < 40; i++) begin
      randomize_cur();
      cycle();
    end

    #2 Reset_n = 1'b0;
    #1 check_reset_state();
    @(negedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      randomize_cur();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
